// File: rtl/csr_hpm_unit.sv
// Hardware performance-monitor CSR bank: mhpmcounter/mhpmevent/mcountinhibit/mcounteren
// plus user aliases, with event selection, privilege filtering and sticky overflow IRQ.
module csr_hpm_unit #(
  parameter int unsigned NUM_CNT   = 4,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned EVENT_NUM = 16,
  parameter int unsigned EVW       = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_en,
  input  logic                     csr_wen,
  input  logic [11:0]              csr_addr,
  input  logic [XLEN-1:0]          csr_wdata,
  input  logic [1:0]               mode,
  input  logic [EVENT_NUM*EVW-1:0] events,
  output logic                     csr_hit,
  output logic                     csr_illegal,
  output logic [XLEN-1:0]          csr_rdata,
  output logic                     ovf_irq
);

  localparam int unsigned FIRST = 3;
  localparam int unsigned LAST  = FIRST + NUM_CNT - 1;
  localparam int unsigned HW    = CNT_WIDTH - XLEN;
  localparam int unsigned SW    = CNT_WIDTH + 1;

  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [7:0]           sel [NUM_CNT];
  logic [NUM_CNT-1:0]   uinh, sinh, minh, ofie, of;
  logic [NUM_CNT-1:0]   inh, cen;

  logic [EVW-1:0]       inc [NUM_CNT];
  logic [SW-1:0]        sum [NUM_CNT];
  logic [NUM_CNT-1:0]   wr_lo, wr_hi, wr_ev, ovf_set;

  logic [4:0] idx;
  logic       idx_ok;
  logic       is_mlo, is_mhi, is_evt, is_ulo, is_uhi, is_inh, is_en, is_user;
  logic       en_bit, priv_bad, wr;

  // Address decode: counter-indexed groups occupy 32-entry windows
  assign idx     = csr_addr[4:0];
  assign idx_ok  = (idx >= 5'(FIRST)) && (idx <= 5'(LAST));
  assign is_mlo  = (csr_addr[11:5] == 7'h58);
  assign is_mhi  = (csr_addr[11:5] == 7'h5C);
  assign is_evt  = (csr_addr[11:5] == 7'h19);
  assign is_ulo  = (csr_addr[11:5] == 7'h60);
  assign is_uhi  = (csr_addr[11:5] == 7'h64);
  assign is_inh  = (csr_addr == 12'h320);
  assign is_en   = (csr_addr == 12'h306);
  assign is_user = is_ulo | is_uhi;

  assign csr_hit  = ((is_mlo | is_mhi | is_evt | is_ulo | is_uhi) & idx_ok) | is_inh | is_en;
  assign priv_bad = (mode < csr_addr[9:8]);
  assign csr_illegal = csr_en & csr_hit &
                       (priv_bad | (is_user & csr_wen) | (is_user & (mode != 2'd3) & ~en_bit));
  assign wr = csr_en & csr_wen & csr_hit & ~csr_illegal;

  // Read mux and per-counter enable lookup
  always_comb begin
    csr_rdata = '0;
    en_bit    = 1'b0;
    if (is_inh) for (int i = 0; i < NUM_CNT; i++) csr_rdata[FIRST+i] = inh[i];
    if (is_en)  for (int i = 0; i < NUM_CNT; i++) csr_rdata[FIRST+i] = cen[i];
    for (int i = 0; i < NUM_CNT; i++) begin
      if (idx == 5'(FIRST + i)) begin
        en_bit = cen[i];
        if (is_mlo | is_ulo) csr_rdata = cnt[i][XLEN-1:0];
        if (is_mhi | is_uhi) csr_rdata = XLEN'(cnt[i][CNT_WIDTH-1:XLEN]);
        if (is_evt) csr_rdata = XLEN'({of[i], ofie[i], minh[i], sinh[i], 1'b0, uinh[i],
                                       18'b0, sel[i]});
      end
    end
  end

  // Per-counter increment, filtering and software-write detection
  always_comb begin
    wr_lo   = '0;
    wr_hi   = '0;
    wr_ev   = '0;
    ovf_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      inc[i] = '0;
      for (int k = 0; k < EVENT_NUM; k++)
        if (sel[i] == 8'(k + 1)) inc[i] = events[k*EVW +: EVW];
      if (inh[i] | ((mode == 2'd3) & minh[i]) | ((mode == 2'd1) & sinh[i]) |
          ((mode == 2'd0) & uinh[i]))
        inc[i] = '0;
      sum[i] = {1'b0, cnt[i]} + SW'(inc[i]);
      if (idx == 5'(FIRST + i)) begin
        wr_lo[i] = wr & is_mlo;
        wr_hi[i] = wr & is_mhi;
        wr_ev[i] = wr & is_evt;
      end
      ovf_set[i] = sum[i][CNT_WIDTH] & ~wr_lo[i] & ~wr_hi[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= '0;
        sel[i] <= '0;
      end
      uinh    <= '0;
      sinh    <= '0;
      minh    <= '0;
      ofie    <= '0;
      of      <= '0;
      inh     <= '0;
      cen     <= '0;
      ovf_irq <= 1'b0;
    end else begin
      ovf_irq <= |(of & ofie);
      if (wr & is_inh) inh <= csr_wdata[LAST:FIRST];
      if (wr & is_en)  cen <= csr_wdata[LAST:FIRST];
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_lo[i])      cnt[i][XLEN-1:0]      <= csr_wdata;
        else if (wr_hi[i]) cnt[i][CNT_WIDTH-1:XLEN] <= csr_wdata[HW-1:0];
        else               cnt[i]                <= sum[i][CNT_WIDTH-1:0];
        // Hardware overflow wins over a same-cycle software clear
        if (wr_ev[i]) begin
          sel[i]  <= csr_wdata[7:0];
          uinh[i] <= csr_wdata[26];
          sinh[i] <= csr_wdata[28];
          minh[i] <= csr_wdata[29];
          ofie[i] <= csr_wdata[30];
          of[i]   <= csr_wdata[31] | ovf_set[i];
        end else if (ovf_set[i]) begin
          of[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_hpm_unit.sv
// Directed self-checking bench for csr_hpm_unit with default parameters.
module tb_csr_hpm_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en, csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  mode;
  logic [31:0] events;
  logic        csr_hit, csr_illegal, ovf_irq;
  logic [31:0] csr_rdata;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [31:0] d;
  logic        ill, h;

  csr_hpm_unit dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_wen(csr_wen), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .mode(mode), .events(events), .csr_hit(csr_hit),
    .csr_illegal(csr_illegal), .csr_rdata(csr_rdata), .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    csr_en = 1'b1; csr_wen = 1'b1; csr_addr = a; csr_wdata = v;
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_wen = 1'b0;
  endtask

  task automatic rd_csr(input logic [11:0] a, output logic [31:0] rd, output logic il,
                        output logic ht);
    @(negedge clk);
    csr_en = 1'b1; csr_wen = 1'b0; csr_addr = a;
    #1;
    rd = csr_rdata; il = csr_illegal; ht = csr_hit;
    csr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tot_cnt++;
    if (ovf_irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", ovf_irq);
    else pass_cnt++;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0 || h !== 1'b1) $display("FAIL reset_cnt3: got %h hit %b want 0 hit 1", d, h);
    else pass_cnt++;
    rd_csr(12'h323, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL reset_evt3: got %h want 0", d);
    else pass_cnt++;
  endtask

  task automatic test_count();
    wr_csr(12'h323, 32'h2);
    @(negedge clk);
    events = 32'h2 << 2;
    repeat (10) @(posedge clk);
    #1;
    events = '0;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'd20) $display("FAIL count_lo: got %0d want 20", d);
    else pass_cnt++;
    rd_csr(12'hC83, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0 || ill !== 1'b0) $display("FAIL count_hi_alias: got %h ill %b want 0 ill 0", d, ill);
    else pass_cnt++;
    rd_csr(12'hB04, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL count_sel0: got %h want 0", d);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    wr_csr(12'hB83, 32'hFFFF_FFFF);
    wr_csr(12'hB03, 32'hFFFF_FFFE);
    wr_csr(12'h323, 32'h4000_0001);
    @(negedge clk);
    events = 32'h1;
    @(posedge clk);
    #1;
    csr_addr = 12'hB03; csr_en = 1'b1;
    #1;
    tot_cnt++;
    if (csr_rdata !== 32'hFFFF_FFFF) $display("FAIL ovf_pre: got %h want ffffffff", csr_rdata);
    else pass_cnt++;
    csr_en = 1'b0;
    @(posedge clk);
    #1;
    events = '0;
    tot_cnt++;
    if (ovf_irq !== 1'b0) $display("FAIL ovf_irq_early: got %b want 0", ovf_irq);
    else pass_cnt++;
    csr_addr = 12'hB03; csr_en = 1'b1;
    #1;
    tot_cnt++;
    if (csr_rdata !== 32'h0) $display("FAIL ovf_wrap_lo: got %h want 0", csr_rdata);
    else pass_cnt++;
    csr_addr = 12'hB83;
    #1;
    tot_cnt++;
    if (csr_rdata !== 32'h0) $display("FAIL ovf_wrap_hi: got %h want 0", csr_rdata);
    else pass_cnt++;
    csr_en = 1'b0;
    @(posedge clk);
    #1;
    tot_cnt++;
    if (ovf_irq !== 1'b1) $display("FAIL ovf_irq_set: got %b want 1", ovf_irq);
    else pass_cnt++;
    rd_csr(12'h323, d, ill, h);
    tot_cnt++;
    if (d !== 32'hC000_0001) $display("FAIL ovf_flag: got %h want c0000001", d);
    else pass_cnt++;
    wr_csr(12'h323, 32'h4000_0001);
    tot_cnt++;
    if (ovf_irq !== 1'b1) $display("FAIL ovf_irq_hold: got %b want 1", ovf_irq);
    else pass_cnt++;
    @(posedge clk);
    #1;
    tot_cnt++;
    if (ovf_irq !== 1'b0) $display("FAIL ovf_irq_drop: got %b want 0", ovf_irq);
    else pass_cnt++;
  endtask

  task automatic test_hw_wins();
    wr_csr(12'hB83, 32'hFFFF_FFFF);
    wr_csr(12'hB03, 32'hFFFF_FFFF);
    @(negedge clk);
    events = 32'h1;
    csr_en = 1'b1; csr_wen = 1'b1; csr_addr = 12'h323; csr_wdata = 32'h4000_0001;
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_wen = 1'b0; events = '0;
    rd_csr(12'h323, d, ill, h);
    tot_cnt++;
    if (d !== 32'hC000_0001) $display("FAIL hw_wins_of: got %h want c0000001", d);
    else pass_cnt++;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL hw_wins_cnt: got %h want 0", d);
    else pass_cnt++;
    wr_csr(12'h323, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_suppress();
    wr_csr(12'h323, 32'h1);
    wr_csr(12'hB83, 32'h0);
    @(negedge clk);
    events = 32'h1;
    wr_csr(12'hB03, 32'd100);
    csr_addr = 12'hB03; csr_en = 1'b1;
    #1;
    tot_cnt++;
    if (csr_rdata !== 32'd100) $display("FAIL wsup_now: got %0d want 100", csr_rdata);
    else pass_cnt++;
    @(posedge clk);
    #1;
    tot_cnt++;
    if (csr_rdata !== 32'd101) $display("FAIL wsup_next: got %0d want 101", csr_rdata);
    else pass_cnt++;
    csr_en = 1'b0; events = '0;
  endtask

  task automatic test_inhibit();
    wr_csr(12'h323, 32'h2000_0001);
    wr_csr(12'hB03, 32'h0);
    @(negedge clk);
    events = 32'h1;
    repeat (5) @(posedge clk);
    #1;
    mode = 2'd0;
    csr_addr = 12'hB03; csr_en = 1'b1;
    #1;
    tot_cnt++;
    if (csr_rdata !== 32'h0) $display("FAIL minh_frozen: got %0d want 0", csr_rdata);
    else pass_cnt++;
    csr_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    events = '0; mode = 2'd3;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'd5) $display("FAIL minh_umode: got %0d want 5", d);
    else pass_cnt++;
    wr_csr(12'h323, 32'h1);
    wr_csr(12'h320, 32'h8);
    @(negedge clk);
    events = 32'h1;
    repeat (4) @(posedge clk);
    #1;
    events = '0;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'd5) $display("FAIL mcountinhibit: got %0d want 5", d);
    else pass_cnt++;
    wr_csr(12'h320, 32'hFFFF_FFFF);
    rd_csr(12'h320, d, ill, h);
    tot_cnt++;
    if (d !== 32'h78) $display("FAIL inhibit_mask: got %h want 78", d);
    else pass_cnt++;
    wr_csr(12'h320, 32'h0);
  endtask

  task automatic test_counteren();
    mode = 2'd0;
    rd_csr(12'hC03, d, ill, h);
    tot_cnt++;
    if (ill !== 1'b1 || h !== 1'b1) $display("FAIL cen_off: got ill %b hit %b want 1 1", ill, h);
    else pass_cnt++;
    mode = 2'd3;
    wr_csr(12'h306, 32'h8);
    mode = 2'd0;
    rd_csr(12'hC03, d, ill, h);
    tot_cnt++;
    if (ill !== 1'b0 || d !== 32'd5) $display("FAIL cen_on: got ill %b data %0d want 0 5", ill, d);
    else pass_cnt++;
    mode = 2'd3;
    wr_csr(12'h306, 32'hFFFF_FFFF);
    rd_csr(12'h306, d, ill, h);
    tot_cnt++;
    if (d !== 32'h78) $display("FAIL cen_mask: got %h want 78", d);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    csr_en = 1'b1; csr_wen = 1'b1; csr_addr = 12'hC03; csr_wdata = 32'h1234;
    #1;
    tot_cnt++;
    if (csr_illegal !== 1'b1) $display("FAIL alias_write_ill: got %b want 1", csr_illegal);
    else pass_cnt++;
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_wen = 1'b0;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'd5) $display("FAIL alias_write_noeff: got %0d want 5", d);
    else pass_cnt++;
    rd_csr(12'hB1F, d, ill, h);
    tot_cnt++;
    if (h !== 1'b0 || d !== 32'h0) $display("FAIL unimpl_b1f: got hit %b data %h want 0 0", h, d);
    else pass_cnt++;
    rd_csr(12'h321, d, ill, h);
    tot_cnt++;
    if (h !== 1'b0) $display("FAIL unimpl_321: got hit %b want 0", h);
    else pass_cnt++;
    mode = 2'd1;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (ill !== 1'b1) $display("FAIL smode_mcsr: got ill %b want 1", ill);
    else pass_cnt++;
    mode = 2'd3;
  endtask

  task automatic test_sel_oob();
    wr_csr(12'h323, 32'h11);
    rd_csr(12'h323, d, ill, h);
    tot_cnt++;
    if (d !== 32'h11) $display("FAIL sel_oob_read: got %h want 11", d);
    else pass_cnt++;
    @(negedge clk);
    events = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    events = '0;
    rd_csr(12'hB03, d, ill, h);
    tot_cnt++;
    if (d !== 32'd5) $display("FAIL sel_oob_count: got %0d want 5", d);
    else pass_cnt++;
    wr_csr(12'h323, 32'hFFFF_FFFF);
    rd_csr(12'h323, d, ill, h);
    tot_cnt++;
    if (d !== 32'hF400_00FF) $display("FAIL evt_fields: got %h want f40000ff", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_count();
    wr_csr(12'h324, 32'h1);
    @(negedge clk);
    events = 32'h1;
    repeat (3) @(posedge clk);
    tot_cnt++;
    if (ovf_irq !== 1'b1) $display("FAIL pre_rst_irq: got %b want 1", ovf_irq);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    tot_cnt++;
    if (ovf_irq !== 1'b0) $display("FAIL rst_mid_irq: got %b want 0", ovf_irq);
    else pass_cnt++;
    rd_csr(12'hB04, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL rst_mid_cnt4: got %h want 0", d);
    else pass_cnt++;
    rd_csr(12'h323, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL rst_mid_evt3: got %h want 0", d);
    else pass_cnt++;
    rd_csr(12'h306, d, ill, h);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL rst_mid_cen: got %h want 0", d);
    else pass_cnt++;
    events = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csr_en = 1'b0; csr_wen = 1'b0; csr_addr = '0; csr_wdata = '0;
    mode = 2'd3; events = '0;
    test_reset();
    test_count();
    test_overflow();
    test_hw_wins();
    test_write_suppress();
    test_inhibit();
    test_counteren();
    test_illegal();
    test_sel_oob();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
